// File: rtl/doodle_game_sequencer_if.sv
// Platform table read port: the sequencer drives the index, the platform
// store answers combinationally with the entry at that index.
interface doodle_game_sequencer_if #(
  parameter int NUM_BLOCKS = 8
);
  localparam int IW = $clog2(NUM_BLOCKS);

  logic [IW-1:0] blk_idx;
  logic [31:0]   blk_x;
  logic [31:0]   blk_y;
  logic          blk_valid;

  modport master (
    output blk_idx,
    input  blk_x,
    input  blk_y,
    input  blk_valid
  );

  modport slave (
    input  blk_idx,
    output blk_x,
    output blk_y,
    output blk_valid
  );
endinterface

// File: rtl/doodle_game_sequencer.sv
// Game controller for the doodle physics datapath. It divides clk into physics
// ticks, scans the platform table for a landing before every tick, drives the
// doodle block's tick/collide/reset inputs and keeps score and game-over state.
module doodle_game_sequencer #(
  parameter int BLOCK_WIDTH  = 40,
  parameter int BLOCK_HEIGHT = 5,
  parameter int NUM_BLOCKS   = 8,
  parameter int TICK_DIV     = 250000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [31:0]                    doodle_x,
  input  logic [31:0]                    doodle_y,
  input  logic                           falling,
  doodle_game_sequencer_if.master        blk,
  output logic                           physics_update,
  output logic                           has_collide,
  output logic                           doodle_reset,
  output logic [2:0]                     game_state,
  output logic                           game_over,
  output logic [15:0]                    score
);

  localparam int IW = $clog2(NUM_BLOCKS);
  // Counter width never collapses to zero when TICK_DIV is 1.
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_SCAN = 3'd2,
    S_TICK = 3'd3,
    S_OVER = 3'd4
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          acc;
  logic          hit;

  // Landing test for one platform entry; right edge exclusive, top edge
  // inclusive, sums widened to 33 bits so a platform near 2^32 never wraps.
  function automatic logic entry_hit(input logic [31:0] bx, input logic [31:0] by,
                                     input logic [31:0] dx, input logic [31:0] dy,
                                     input logic v, input logic f);
    logic [32:0] x_end;
    logic [32:0] y_top;
    x_end = {1'b0, bx} + 33'(BLOCK_WIDTH);
    y_top = {1'b0, by} + 33'(BLOCK_HEIGHT);
    return v && f && (dx >= bx) && ({1'b0, dx} < x_end) &&
           (dy >= by) && ({1'b0, dy} <= y_top);
  endfunction

  // Score increment that sticks at the 16-bit ceiling.
  function automatic logic [15:0] sat_inc(input logic [15:0] s);
    return (s == 16'hFFFF) ? s : s + 16'd1;
  endfunction

  assign hit         = entry_hit(blk.blk_x, blk.blk_y, doodle_x, doodle_y,
                                 blk.blk_valid, falling);
  assign blk.blk_idx = idx;
  assign game_state  = state;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic: wait out the tick divider, scan every entry, tick once.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: if (start) state_next = S_WAIT;
      S_WAIT: if (cnt == CW'(TICK_DIV - 1)) state_next = S_SCAN;
      S_SCAN: if (idx == IW'(NUM_BLOCKS - 1)) state_next = S_TICK;
      S_TICK: begin
        if (falling && !has_collide && (doodle_y == 32'd0)) state_next = S_OVER;
        else                                                state_next = S_WAIT;
      end
      S_OVER: if (start) state_next = S_WAIT;
      default: state_next = S_IDLE;
    endcase
  end

  // Tick divider and scan accumulator; both self-clear outside their state.
  always_ff @(posedge clk) begin
    cnt <= (state == S_WAIT) ? cnt + CW'(1) : '0;
    acc <= (state == S_SCAN) ? (acc | hit) : 1'b0;
  end

  // Registered outputs, decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx            <= '0;
      physics_update <= 1'b0;
      has_collide    <= 1'b0;
      score          <= 16'd0;
      doodle_reset   <= 1'b1;
      game_over      <= 1'b0;
    end else begin
      physics_update <= (state_next == S_TICK);
      doodle_reset   <= (state_next == S_IDLE) || (state_next == S_OVER);
      game_over      <= (state_next == S_OVER);
      idx            <= ((state == S_SCAN) && (state_next == S_SCAN)) ? idx + IW'(1) : '0;
      if ((state == S_SCAN) && (state_next == S_TICK))
        has_collide <= acc | hit;
      else if ((state == S_OVER) && start)
        has_collide <= 1'b0;
      if (((state == S_IDLE) || (state == S_OVER)) && start)
        score <= 16'd0;
      else if ((state == S_TICK) && has_collide)
        score <= sat_inc(score);
    end
  end

endmodule

// File: tb/tb_doodle_game_sequencer.sv
// Bench for doodle_game_sequencer with TICK_DIV=4, NUM_BLOCKS=4 (period 9).
// The reference model tracks play as a position within the tick period and
// evaluates landings directly over the platform table.
module tb_doodle_game_sequencer;
  localparam int TD = 4;
  localparam int NB = 4;
  localparam int P  = TD + NB + 1;
  localparam int BW = 40;
  localparam int BH = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, falling;
  logic [31:0] doodle_x, doodle_y;
  logic        physics_update, has_collide, doodle_reset, game_over;
  logic [2:0]  game_state;
  logic [15:0] score;

  logic [31:0] plat_x [NB];
  logic [31:0] plat_y [NB];
  logic        plat_v [NB];

  doodle_game_sequencer_if #(.NUM_BLOCKS(NB)) bus ();
  assign bus.blk_x     = plat_x[bus.blk_idx];
  assign bus.blk_y     = plat_y[bus.blk_idx];
  assign bus.blk_valid = plat_v[bus.blk_idx];

  doodle_game_sequencer #(
    .BLOCK_WIDTH(BW), .BLOCK_HEIGHT(BH), .NUM_BLOCKS(NB), .TICK_DIV(TD)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .doodle_x(doodle_x), .doodle_y(doodle_y), .falling(falling),
    .blk(bus),
    .physics_update(physics_update), .has_collide(has_collide),
    .doodle_reset(doodle_reset), .game_state(game_state),
    .game_over(game_over), .score(score)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Model: mode 0 idle, 1 playing, 2 over; m_p = position in tick period.
  int          m_mode = 0;
  int          m_p = 0;
  logic [15:0] m_score = 16'd0;
  logic        m_hc = 1'b0;
  int          hist [5];

  function automatic bit model_hit();
    bit h;
    logic [63:0] dx, dy, bx, by;
    h = 0;
    dx = {32'd0, doodle_x};
    dy = {32'd0, doodle_y};
    for (int i = 0; i < NB; i++) begin
      bx = {32'd0, plat_x[i]};
      by = {32'd0, plat_y[i]};
      if (plat_v[i] && falling && dx >= bx && dx < bx + BW && dy >= by && dy <= by + BH)
        h = 1;
    end
    return h;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      m_mode = 0; m_p = 0; m_score = 16'd0; m_hc = 1'b0;
    end else if (m_mode == 0) begin
      if (start) begin m_mode = 1; m_p = 0; m_score = 16'd0; end
    end else if (m_mode == 2) begin
      if (start) begin m_mode = 1; m_p = 0; m_score = 16'd0; m_hc = 1'b0; end
    end else if (m_p == P - 1) begin
      if (m_hc && m_score != 16'hFFFF) m_score = m_score + 16'd1;
      if (falling && !m_hc && doodle_y == 32'd0) m_mode = 2;
      else m_p = 0;
    end else begin
      m_p = m_p + 1;
      if (m_p == P - 1) m_hc = model_hit();
    end
  endtask

  task automatic compare_all();
    int es, ei;
    if (m_mode == 0)       es = 0;
    else if (m_mode == 2)  es = 4;
    else if (m_p < TD)     es = 1;
    else if (m_p < TD + NB) es = 2;
    else                   es = 3;
    ei = (es == 2) ? m_p - TD : 0;
    check("game_state", 32'(game_state), 32'(es));
    check("blk_idx", 32'(bus.blk_idx), 32'(ei));
    check("physics_update", 32'(physics_update), 32'(es == 3));
    check("doodle_reset", 32'(doodle_reset), 32'(m_mode != 1));
    check("game_over", 32'(game_over), 32'(m_mode == 2));
    check("score", 32'(score), 32'(m_score));
    check("has_collide", 32'(has_collide), 32'(m_hc));
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    model_edge();
    @(negedge clk);
    compare_all();
    for (int i = 0; i < 4; i++) hist[i] = hist[i + 1];
    hist[4] = int'(bus.blk_idx);
  endtask

  task automatic run_to_tick(output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!physics_update && n < 20);
    if (!physics_update) begin
      vectors++;
      miscompares++;
      $display("FAIL tick_timeout: got no physics_update, expected one within 20 cycles");
    end
  endtask

  task automatic check_idx_seq();
    for (int i = 0; i < 4; i++) check("scan_idx_seq", 32'(hist[i]), 32'(i));
  endtask

  // Landing vectors against platform 2 at (100,50): x, y, falling, valid2, hit, score at tick.
  int   vx [8] = '{120, 140, 139, 100,  99, 120, 120, 120};
  int   vy [8] = '{ 52,  52,  55,  50,  52,  56,  52,  52};
  bit   vf [8] = '{  1,   1,   1,   1,   1,   1,   0,   1};
  bit   vv [8] = '{  1,   1,   1,   1,   1,   1,   1,   0};
  bit   vh [8] = '{  1,   0,   1,   1,   0,   0,   0,   0};
  int   vs [8] = '{  0,   1,   1,   2,   3,   3,   3,   3};

  initial begin
    int n;
    bit found;
    reset = 1'b1; start = 1'b0; falling = 1'b0;
    doodle_x = 32'd600; doodle_y = 32'd200;
    plat_x[0] = 32'd300; plat_y[0] = 32'd300; plat_v[0] = 1'b1;
    plat_x[1] = 32'd110; plat_y[1] = 32'd45;  plat_v[1] = 1'b0;
    plat_x[2] = 32'd100; plat_y[2] = 32'd50;  plat_v[2] = 1'b1;
    plat_x[3] = 32'd500; plat_y[3] = 32'd10;  plat_v[3] = 1'b1;
    for (int i = 0; i < 5; i++) hist[i] = 0;

    @(negedge clk);
    cycle();
    cycle();
    check("rst_state", 32'(game_state), 32'd0);
    check("rst_doodle_reset", 32'(doodle_reset), 32'd1);
    check("rst_score", 32'(score), 32'd0);
    check("rst_pu", 32'(physics_update), 32'd0);
    reset = 1'b0;
    cycle();

    // Start held for one cycle; first pulse lands in the ninth period counting
    // the one where start is sampled, i.e. eight cycles after that one.
    start = 1'b1;
    cycle();
    start = 1'b0;
    run_to_tick(n);
    check("first_tick_latency", 32'(n), 32'd8);
    check_idx_seq();
    check("first_tick_hc", 32'(has_collide), 32'd0);

    for (int k = 0; k < 8; k++) begin
      doodle_x = 32'(vx[k]);
      doodle_y = 32'(vy[k]);
      falling  = vf[k];
      plat_v[2] = vv[k];
      run_to_tick(n);
      check("tick_period", 32'(n), 32'(P));
      check_idx_seq();
      check("landing_hc", 32'(has_collide), 32'(vh[k]));
      check("landing_score", 32'(score), 32'(vs[k]));
    end
    cycle();
    check("score_after_hits", 32'(score), 32'd3);

    // Game over: falling at y=0 with nothing under the doodle.
    plat_v[2] = 1'b1;
    doodle_x = 32'd600; doodle_y = 32'd0; falling = 1'b1;
    run_to_tick(n);
    check("go_tick_latency", 32'(n), 32'd8);
    check("go_hc", 32'(has_collide), 32'd0);
    cycle();
    check("go_state", 32'(game_state), 32'd4);
    check("go_flag", 32'(game_over), 32'd1);
    check("go_doodle_reset", 32'(doodle_reset), 32'd1);
    check("go_score_held", 32'(score), 32'd3);
    cycle();
    cycle();
    check("go_state_hold", 32'(game_state), 32'd4);
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("restart_state", 32'(game_state), 32'd1);
    check("restart_score", 32'(score), 32'd0);
    check("restart_hc", 32'(has_collide), 32'd0);

    // Reset while the scan sits on entry 2.
    doodle_y = 32'd200;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (game_state == 3'd2 && bus.blk_idx == 2'd2) found = 1;
    end
    check("scan_reached", 32'(found), 32'd1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("midscan_state", 32'(game_state), 32'd0);
    check("midscan_idx", 32'(bus.blk_idx), 32'd0);
    check("midscan_pu", 32'(physics_update), 32'd0);
    check("midscan_doodle_reset", 32'(doodle_reset), 32'd1);

    // Saturation: preload score near the ceiling, then three landing ticks.
    doodle_x = 32'd120; doodle_y = 32'd52; falling = 1'b1;
    start = 1'b1;
    cycle();
    start = 1'b0;
    force dut.score = 16'hFFFE;
    m_score = 16'hFFFE;
    cycle();
    release dut.score;
    for (int k = 0; k < 3; k++) begin
      run_to_tick(n);
      cycle();
      check("sat_score", 32'(score), 32'h0000FFFF);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
